// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: stage bit map,
// register address width and the sequencer state encoding.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int N_STG      = 5;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_BUS_WAIT  = 2'd2,
    ST_IRQ_DRAIN = 2'd3
  } state_e;

  // Holding stage k must also hold every stage upstream of it.
  function automatic logic [N_STG-1:0] stall_upto(input int stg);
    logic [N_STG-1:0] m;
    m = '0;
    for (int i = 0; i < N_STG; i++) begin
      if (i <= stg) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load
// currently in EX has not produced yet.
module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  ex_load,
  input  logic                  ex_w_reg_req,
  input  logic [REG_ADDR_W-1:0] ex_w_reg_addr,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used & (rs1_addr == ex_w_reg_addr);
  assign rs2_hit = rs2_used & (rs2_addr == ex_w_reg_addr);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign hazard = ex_load & ex_w_reg_req & (ex_w_reg_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns load-use, divide, bus wait, redirect and
// interrupt-drain conditions into per-stage stall/flush controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_load_i,
  input  logic                  ex_w_reg_req_i,
  input  logic [REG_ADDR_W-1:0] ex_w_reg_addr_i,
  input  logic                  ex_redirect_i,
  input  logic                  div_start_i,
  input  logic                  div_done_i,
  input  logic                  mem_bus_req_i,
  input  logic                  mem_bus_ack_i,
  input  logic                  irq_req_i,
  output logic [N_STG-1:0]      stall_o,
  output logic [N_STG-1:0]      flush_o,
  output logic                  redirect_o,
  output logic                  irq_ack_o,
  output logic                  bus_err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_pend_q, redirect_pend_d;
  logic             div_pend_q, div_pend_d;
  logic             bus_err_q, bus_err_d;

  logic             load_use;
  logic             bus_stall_start;
  logic [N_STG-1:0] stall_raw;
  logic [N_STG-1:0] flush_raw;
  logic             redirect;
  logic             irq_ack;

  pipe_hazard_ctrl_load_use_detect u_load_use (
    .rs1_addr      (id_rs1_addr_i),
    .rs2_addr      (id_rs2_addr_i),
    .rs1_used      (id_rs1_used_i),
    .rs2_used      (id_rs2_used_i),
    .ex_load       (ex_load_i),
    .ex_w_reg_req  (ex_w_reg_req_i),
    .ex_w_reg_addr (ex_w_reg_addr_i),
    .hazard        (load_use)
  );

  assign bus_stall_start = mem_bus_req_i & ~mem_bus_ack_i;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    redirect_pend_d = redirect_pend_q;
    div_pend_d      = div_pend_q;
    bus_err_d       = 1'b0;
    stall_raw       = '0;
    flush_raw       = '0;
    redirect        = 1'b0;
    irq_ack         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_use) begin
          stall_raw            = stall_upto(STG_IF_ID);
          flush_raw[STG_ID_EX] = 1'b1;
        end
        // Abandoned bus access: the EX/MEM slot feeding the dead access is bubbled.
        if (bus_err_q) flush_raw[STG_EX_MEM] = 1'b1;
        if (bus_stall_start) begin
          state_d    = ST_BUS_WAIT;
          cnt_d      = CNT_W'(1);
          div_pend_d = div_start_i & ~div_done_i;
        end else if (div_start_i & ~div_done_i) begin
          state_d = ST_DIV_WAIT;
        end else if (irq_req_i & ~ex_redirect_i & ~redirect_pend_q) begin
          state_d = ST_IRQ_DRAIN;
        end
      end

      ST_DIV_WAIT: begin
        stall_raw             = stall_upto(STG_ID_EX);
        flush_raw[STG_EX_MEM] = 1'b1;
        if (bus_stall_start) begin
          state_d    = ST_BUS_WAIT;
          cnt_d      = CNT_W'(1);
          div_pend_d = ~div_done_i;
        end else if (div_done_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS_WAIT: begin
        stall_raw             = stall_upto(STG_EX_MEM);
        flush_raw[STG_MEM_WB] = 1'b1;
        if (div_done_i) div_pend_d = 1'b0;
        if (mem_bus_ack_i || cnt_q == CNT_W'(BUS_TIMEOUT)) begin
          state_d    = (div_pend_q & ~div_done_i) ? ST_DIV_WAIT : ST_IDLE;
          cnt_d      = '0;
          div_pend_d = 1'b0;
          bus_err_d  = ~mem_bus_ack_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IRQ_DRAIN: begin
        if (!irq_req_i) begin
          state_d = ST_IDLE;
        end else begin
          stall_raw[STG_PC]    = 1'b1;
          flush_raw[STG_IF_ID] = 1'b1;
          if (!(ex_load_i | div_start_i | mem_bus_req_i)) begin
            irq_ack = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A redirect waits for EX to advance; when it fires it overrides PC/IF holds.
    if ((ex_redirect_i | redirect_pend_q) & ~stall_raw[STG_ID_EX]) begin
      redirect             = 1'b1;
      redirect_pend_d      = 1'b0;
      flush_raw[STG_IF_ID] = 1'b1;
      flush_raw[STG_ID_EX] = 1'b1;
      stall_raw[STG_PC]    = 1'b0;
      stall_raw[STG_IF_ID] = 1'b0;
    end else if (ex_redirect_i) begin
      redirect_pend_d = 1'b1;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_o    = rst_n ? (stall_raw & ~flush_raw) : '0;
  assign flush_o    = rst_n ? flush_raw : '0;
  assign redirect_o = rst_n & redirect;
  assign irq_ack_o  = rst_n & irq_ack;
  assign bus_err_o  = rst_n & bus_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      redirect_pend_q <= 1'b0;
      div_pend_q      <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      redirect_pend_q <= redirect_pend_d;
      div_pend_q      <= div_pend_d;
      bus_err_q       <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected outputs are queued as
// each cycle's stimulus is applied and compared when the cycle is sampled.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i, id_rs2_addr_i, ex_w_reg_addr_i;
  logic                  id_rs1_used_i, id_rs2_used_i, ex_load_i, ex_w_reg_req_i;
  logic                  ex_redirect_i, div_start_i, div_done_i;
  logic                  mem_bus_req_i, mem_bus_ack_i, irq_req_i;
  logic [N_STG-1:0]      stall_o, flush_o;
  logic                  redirect_o, irq_ack_o, bus_err_o;

  typedef struct packed {
    logic [4:0] stall;
    logic [4:0] flush;
    logic       red;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  outs;
  int    n_vec  = 0;
  int    n_miss = 0;

  assign outs = '{stall_o, flush_o, redirect_o, irq_ack_o, bus_err_o};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BUS_TIMEOUT(4), .CNT_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs1_used_i   (id_rs1_used_i),
    .id_rs2_used_i   (id_rs2_used_i),
    .ex_load_i       (ex_load_i),
    .ex_w_reg_req_i  (ex_w_reg_req_i),
    .ex_w_reg_addr_i (ex_w_reg_addr_i),
    .ex_redirect_i   (ex_redirect_i),
    .div_start_i     (div_start_i),
    .div_done_i      (div_done_i),
    .mem_bus_req_i   (mem_bus_req_i),
    .mem_bus_ack_i   (mem_bus_ack_i),
    .irq_req_i       (irq_req_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .redirect_o      (redirect_o),
    .irq_ack_o       (irq_ack_o),
    .bus_err_o       (bus_err_o)
  );

  task automatic check(input string tag, input exp_t got, input exp_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got stall=%b flush=%b red=%b ack=%b err=%b, expected stall=%b flush=%b red=%b ack=%b err=%b",
               tag, got.stall, got.flush, got.red, got.ack, got.err,
               want.stall, want.flush, want.red, want.ack, want.err);
    end
  endtask

  task automatic clr();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_w_reg_addr_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_load_i = 1'b0; ex_w_reg_req_i = 1'b0; ex_redirect_i = 1'b0;
    div_start_i = 1'b0; div_done_i = 1'b0;
    mem_bus_req_i = 1'b0; mem_bus_ack_i = 1'b0; irq_req_i = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    ex_load_i = 1'b1; ex_w_reg_req_i = 1'b1; ex_w_reg_addr_i = rd;
  endtask

  // Queue this cycle's expectation, sample on the falling edge, then advance.
  task automatic step(input string tag, input logic [4:0] s, input logic [4:0] f,
                      input logic r, input logic a, input logic e);
    exp_t  want;
    string t;
    exp_q.push_back('{s, f, r, a, e});
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    check(t, outs, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    load_in_ex(5'd5); id_rs1_addr_i = 5'd5; id_rs1_used_i = 1'b1;
    #3;
    check("reset_outputs", outs, '0);
    #9 rst_n = 1'b1;
    clr();
    @(posedge clk); #1;

    // Load-use on rs1, then register zero, then rs2 with/without use.
    load_in_ex(5'd5); id_rs1_addr_i = 5'd5; id_rs1_used_i = 1'b1;
    step("lu_rs1", 5'b00011, 5'b00100, 0, 0, 0);
    clr();
    step("lu_released", 5'b00000, 5'b00000, 0, 0, 0);
    load_in_ex(5'd0); id_rs1_addr_i = 5'd0; id_rs1_used_i = 1'b1;
    step("lu_x0", 5'b00000, 5'b00000, 0, 0, 0);
    clr(); load_in_ex(5'd7); id_rs2_addr_i = 5'd7; id_rs2_used_i = 1'b1;
    step("lu_rs2", 5'b00011, 5'b00100, 0, 0, 0);
    id_rs2_used_i = 1'b0;
    step("lu_rs2_unused", 5'b00000, 5'b00000, 0, 0, 0);

    // Redirect beats load-use in the same cycle.
    load_in_ex(5'd9); id_rs1_addr_i = 5'd9; id_rs1_used_i = 1'b1; ex_redirect_i = 1'b1;
    step("redir_vs_lu", 5'b00000, 5'b00110, 1, 0, 0);
    clr();

    // Divide: start at cycle 0, done at cycle 8.
    div_start_i = 1'b1;
    step("div_c0", 5'b00000, 5'b00000, 0, 0, 0);
    clr();
    for (int c = 1; c <= 7; c++) step($sformatf("div_c%0d", c), 5'b00111, 5'b01000, 0, 0, 0);
    div_done_i = 1'b1;
    step("div_c8_done", 5'b00111, 5'b01000, 0, 0, 0);
    clr();
    step("div_c9", 5'b00000, 5'b00000, 0, 0, 0);
    div_start_i = 1'b1; div_done_i = 1'b1;
    step("div_instant", 5'b00000, 5'b00000, 0, 0, 0);
    clr();
    step("div_instant_next", 5'b00000, 5'b00000, 0, 0, 0);

    // Bus timeout with BUS_TIMEOUT=4.
    mem_bus_req_i = 1'b1;
    step("bto_c0", 5'b00000, 5'b00000, 0, 0, 0);
    for (int c = 1; c <= 4; c++) step($sformatf("bto_c%0d", c), 5'b01111, 5'b10000, 0, 0, 0);
    clr();
    step("bto_err", 5'b00000, 5'b01000, 0, 0, 1);
    step("bto_after", 5'b00000, 5'b00000, 0, 0, 0);

    // Bus acked at cycle 2: no error.
    mem_bus_req_i = 1'b1;
    step("back_c0", 5'b00000, 5'b00000, 0, 0, 0);
    step("back_c1", 5'b01111, 5'b10000, 0, 0, 0);
    mem_bus_ack_i = 1'b1;
    step("back_c2", 5'b01111, 5'b10000, 0, 0, 0);
    clr();
    step("back_c3", 5'b00000, 5'b00000, 0, 0, 0);
    step("back_c4", 5'b00000, 5'b00000, 0, 0, 0);

    // Redirect arriving during a bus wait is held until EX advances.
    mem_bus_req_i = 1'b1;
    step("rbus_c0", 5'b00000, 5'b00000, 0, 0, 0);
    ex_redirect_i = 1'b1;
    step("rbus_c1", 5'b01111, 5'b10000, 0, 0, 0);
    step("rbus_c2", 5'b01111, 5'b10000, 0, 0, 0);
    mem_bus_ack_i = 1'b1;
    step("rbus_ack", 5'b01111, 5'b10000, 0, 0, 0);
    clr();
    step("rbus_fire", 5'b00000, 5'b00110, 1, 0, 0);
    step("rbus_done", 5'b00000, 5'b00000, 0, 0, 0);

    // Divide completion during a bus wait is remembered on exit.
    div_start_i = 1'b1;
    step("dbus_c0", 5'b00000, 5'b00000, 0, 0, 0);
    clr(); mem_bus_req_i = 1'b1;
    step("dbus_c1", 5'b00111, 5'b01000, 0, 0, 0);
    div_done_i = 1'b1;
    step("dbus_c2", 5'b01111, 5'b10000, 0, 0, 0);
    div_done_i = 1'b0; mem_bus_ack_i = 1'b1;
    step("dbus_c3", 5'b01111, 5'b10000, 0, 0, 0);
    clr();
    step("dbus_c4", 5'b00000, 5'b00000, 0, 0, 0);

    // Interrupt with a load in EX: ack only once the load has left.
    irq_req_i = 1'b1; ex_load_i = 1'b1;
    step("irq_c0", 5'b00000, 5'b00000, 0, 0, 0);
    step("irq_drain", 5'b00001, 5'b00010, 0, 0, 0);
    ex_load_i = 1'b0;
    step("irq_ack", 5'b00001, 5'b00010, 0, 1, 0);
    clr();
    step("irq_after", 5'b00000, 5'b00000, 0, 0, 0);

    // Interrupt withdrawn mid-drain: no ack.
    irq_req_i = 1'b1; ex_load_i = 1'b1;
    step("irqx_c0", 5'b00000, 5'b00000, 0, 0, 0);
    step("irqx_drain", 5'b00001, 5'b00010, 0, 0, 0);
    irq_req_i = 1'b0;
    step("irqx_drop", 5'b00000, 5'b00000, 0, 0, 0);
    ex_load_i = 1'b0;
    step("irqx_idle", 5'b00000, 5'b00000, 0, 0, 0);

    // Reset during a divide wait with a redirect pending.
    div_start_i = 1'b1;
    step("rst_c0", 5'b00000, 5'b00000, 0, 0, 0);
    clr(); ex_redirect_i = 1'b1;
    step("rst_c1", 5'b00111, 5'b01000, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    check("rst_async", outs, '0);
    #1 rst_n = 1'b1;
    clr();
    step("rst_idle", 5'b00000, 5'b00000, 0, 0, 0);
    step("rst_idle2", 5'b00000, 5'b00000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
